// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle registered prom, buffers results in a 2-entry FIFO.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module fetch_unit #(
    parameter int unsigned             ADDR_W   = 16,
    parameter int unsigned             INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]       RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_W-1:0]   prom_addr,
    input  logic [INSTR_W-1:0]  prom_data,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    input  logic                halt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [ADDR_W-1:0]   out_pc,
    output logic                halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_stall
`endif
);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic               inflight;
    logic [INSTR_W-1:0] fifo_instr [2];
    logic [ADDR_W-1:0]  fifo_pc    [2];
    logic               rd_ptr;
    logic               wr_ptr;
    logic [1:0]         count;
    logic               push;
    logic               pop;
    logic               issue;

    assign prom_addr = pc;
    assign out_valid = (count != 2'd0);
    assign out_instr = fifo_instr[rd_ptr];
    assign out_pc    = fifo_pc[rd_ptr];
    assign halted    = (state == HALT);
    assign wr_ptr    = rd_ptr ^ count[0];

    // count + inflight never exceeds 2, so a response always finds a free slot.
    always_comb begin
        state_next = state;
        pop        = out_valid && out_ready;
        push       = inflight && !redirect_valid;
        issue      = (state == FETCH) && !halt && !redirect_valid &&
                     ((({1'b0, count} + {2'b00, inflight}) < 3'd2) || pop);
        case (state)
            FETCH:   if (halt) state_next = HALT;
            HALT:    if (redirect_valid && !halt) state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                pc       <= redirect_pc;
                inflight <= 1'b0;
                rd_ptr   <= 1'b0;
                count    <= 2'd0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    pc          <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                    inflight_pc <= pc;
                end
                if (push) begin
                    fifo_instr[wr_ptr] <= prom_data;
                    fifo_pc[wr_ptr]    <= inflight_pc;
                end
                if (pop) rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (out_valid && out_ready)  perf_fetched <= perf_fetched + 32'd1;
            if (out_valid && !out_ready) perf_stall   <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; prom model returns {tag, addr} one cycle after addr.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] prom_addr;
    logic [31:0] prom_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [15:0] out_pc;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    int          mon_hs = 0;
    int          mon_st = 0;
`endif

    logic [15:0] tag = 16'h0000;
    int          checks = 0;
    int          errors = 0;

    fetch_unit #(.ADDR_W(16), .INSTR_W(32), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .prom_addr      (prom_addr),
        .prom_data      (prom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) prom_data <= {tag, prom_addr};

`ifdef FETCH_PERF_CNT_EN
    always @(negedge clk) begin
        if (rst) begin
            mon_hs = 0;
            mon_st = 0;
        end else begin
            if (out_valid && out_ready)  mon_hs++;
            if (out_valid && !out_ready) mon_st++;
        end
    end
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, halted, out_pc, out_instr} !== {1'b0, 1'b0, 16'h0000, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs got v=%b h=%b pc=%h instr=%h want 0,0,0000,00000000",
                     out_valid, halted, out_pc, out_instr);
        end
        checks++;
        if (prom_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_prom_addr got %h want 0000", prom_addr);
        end
        rst = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_cycle_valid got %b want 0", out_valid);
        end
        step();
    endtask

    task automatic test_stream();
        logic [15:0] p;
        for (int i = 0; i < 4; i++) begin
            p = 16'(i);
            checks++;
            if ({out_valid, out_pc, out_instr} !== {1'b1, p, 16'h0000, p}) begin
                errors++;
                $display("FAIL stream_%0d got v=%b pc=%h instr=%h want 1,%h,%h",
                         i, out_valid, out_pc, out_instr, p, {16'h0000, p});
            end
            step();
        end
    endtask

    task automatic test_stall();
        logic [15:0] p;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, out_pc, out_instr, prom_addr} !== {1'b1, 16'h0004, 32'h4, 16'h0006}) begin
                errors++;
                $display("FAIL stall_%0d got v=%b pc=%h instr=%h addr=%h want 1,0004,00000004,0006",
                         i, out_valid, out_pc, out_instr, prom_addr);
            end
            step();
        end
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            p = 16'(4 + j);
            checks++;
            if ({out_valid, out_pc, out_instr} !== {1'b1, p, 16'h0000, p}) begin
                errors++;
                $display("FAIL release_%0d got v=%b pc=%h instr=%h want 1,%h", j, out_valid, out_pc, out_instr, p);
            end
            step();
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_stall !== 32'd5) begin
            errors++;
            $display("FAIL perf_stall got %0d want 5", perf_stall);
        end
        checks++;
        if (perf_fetched !== 32'd9) begin
            errors++;
            $display("FAIL perf_fetched got %0d want 9", perf_fetched);
        end
`endif
    endtask

    task automatic test_redirect_full();
        logic [15:0] p;
        out_ready = 1'b0;
        step();
        step();
        redirect_valid = 1'b1; redirect_pc = 16'h0040; tag = 16'hBEEF;
        step();
        redirect_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if ({out_valid, prom_addr} !== {1'b0, 16'h0040}) begin
            errors++;
            $display("FAIL redir_r1 got v=%b addr=%h want 0,0040", out_valid, prom_addr);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_r2 got v=%b want 0", out_valid);
        end
        step();
        for (int j = 0; j < 4; j++) begin
            p = 16'h0040 + 16'(j);
            checks++;
            if ({out_valid, out_pc, out_instr} !== {1'b1, p, 16'hBEEF, p}) begin
                errors++;
                $display("FAIL redir_seq_%0d got v=%b pc=%h instr=%h want 1,%h", j, out_valid, out_pc, out_instr, p);
            end
            step();
        end
    endtask

    task automatic test_wrap();
        logic [15:0] p;
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        for (int j = 0; j < 4; j++) begin
            p = 16'hFFFE + 16'(j);
            checks++;
            if ({out_valid, out_pc, out_instr} !== {1'b1, p, 16'hBEEF, p}) begin
                errors++;
                $display("FAIL wrap_%0d got v=%b pc=%h instr=%h want 1,%h", j, out_valid, out_pc, out_instr, p);
            end
            step();
        end
    endtask

    task automatic test_halt();
        halt = 1'b1;
        checks++;
        if ({out_valid, out_pc} !== {1'b1, 16'h0002}) begin
            errors++;
            $display("FAIL halt_h0 got v=%b pc=%h want 1,0002", out_valid, out_pc);
        end
        step();
        halt = 1'b0;
        checks++;
        if ({halted, out_valid, out_pc} !== {1'b1, 1'b1, 16'h0003}) begin
            errors++;
            $display("FAIL halt_h1 got h=%b v=%b pc=%h want 1,1,0003", halted, out_valid, out_pc);
        end
        step();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({halted, out_valid, prom_addr} !== {1'b1, 1'b0, 16'h0004}) begin
                errors++;
                $display("FAIL halt_drained_%0d got h=%b v=%b addr=%h want 1,0,0004", i, halted, out_valid, prom_addr);
            end
            step();
        end
        redirect_valid = 1'b1; redirect_pc = 16'h0010;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_resume got h=%b want 0", halted);
        end
        step();
        step();
        checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 16'h0010, 32'hBEEF0010}) begin
            errors++;
            $display("FAIL halt_resume_pc got v=%b pc=%h instr=%h want 1,0010,beef0010", out_valid, out_pc, out_instr);
        end
        redirect_valid = 1'b1; redirect_pc = 16'h0020; halt = 1'b1;
        step();
        redirect_valid = 1'b0; halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({halted, out_valid, prom_addr} !== {1'b1, 1'b0, 16'h0020}) begin
                errors++;
                $display("FAIL redir_halt_%0d got h=%b v=%b addr=%h want 1,0,0020", i, halted, out_valid, prom_addr);
            end
            step();
        end
        redirect_valid = 1'b1; redirect_pc = 16'h0030;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        checks++;
        if ({halted, out_valid, out_pc} !== {1'b0, 1'b1, 16'h0030}) begin
            errors++;
            $display("FAIL resume2 got h=%b v=%b pc=%h want 0,1,0030", halted, out_valid, out_pc);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        step();
        step();
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if ({perf_fetched, perf_stall} !== {32'(mon_hs), 32'(mon_st)}) begin
            errors++;
            $display("FAIL perf_totals got %0d/%0d want %0d/%0d", perf_fetched, perf_stall, mon_hs, mon_st);
        end
`endif
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, halted, out_pc, out_instr, prom_addr} !== {1'b0, 1'b0, 16'h0000, 32'h0, 16'h0000}) begin
            errors++;
            $display("FAIL midreset got v=%b h=%b pc=%h instr=%h addr=%h want all zero",
                     out_valid, halted, out_pc, out_instr, prom_addr);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if ({perf_fetched, perf_stall} !== 64'h0) begin
            errors++;
            $display("FAIL perf_reset got %0d/%0d want 0/0", perf_fetched, perf_stall);
        end
`endif
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL refetch_c1 got v=%b want 0", out_valid);
        end
        step();
        checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 16'h0000, 32'hBEEF0000}) begin
            errors++;
            $display("FAIL refetch_c2 got v=%b pc=%h instr=%h want 1,0000,beef0000", out_valid, out_pc, out_instr);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_wrap();
        test_halt();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
